// File: rtl/mac_accum_ctrl.sv
// rtl/mac_accum_ctrl.sv - accumulator sequencer driving an external combinational adder
module mac_accum_ctrl #(
    parameter int NBIT  = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_terms,
    input  logic             prod_valid,
    input  logic [NBIT-1:0]  prod_data,
    output logic             prod_ready,
    output logic [NBIT-1:0]  add_a,
    output logic [NBIT-1:0]  add_b,
    input  logic [NBIT-1:0]  add_sum,
    output logic [NBIT-1:0]  acc_out,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [NBIT-1:0]  acc;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            acc     <= '0;
            count   <= '0;
            acc_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (num_terms != '0) begin
                            acc   <= '0;
                            count <= num_terms;
                            state <= S_ACCUM;
                        end else begin
                            acc_out <= '0;
                            state   <= S_DONE;
                        end
                    end
                end
                S_ACCUM: begin
                    // a stall simply holds acc/count; start is not looked at here
                    if (prod_valid) begin
                        acc   <= add_sum;
                        count <= count - 1'b1;
                        if (count == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            acc_out <= add_sum;
                            state   <= S_DONE;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // handshake and status come only from the registered state
    assign prod_ready = (state == S_ACCUM);
    assign done       = (state == S_DONE);
    assign busy       = (state == S_ACCUM) || (state == S_DONE);
    assign add_a      = acc;
    assign add_b      = prod_ready ? prod_data : '0;

endmodule

// File: tb/tb_mac_accum_ctrl.sv
// tb/tb_mac_accum_ctrl.sv - scoreboard bench for mac_accum_ctrl
module tb_mac_accum_ctrl;

    typedef logic [23:0] word_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  num_terms;
    logic        prod_valid;
    word_t       prod_data;
    logic        prod_ready;
    word_t       add_a;
    word_t       add_b;
    word_t       add_sum;
    word_t       acc_out;
    logic        done;
    logic        busy;

    int checks = 0;
    int errors = 0;
    word_t exp_q[$];
    bit after_done = 0;

    mac_accum_ctrl #(.NBIT(24), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_terms(num_terms),
        .prod_valid(prod_valid), .prod_data(prod_data), .prod_ready(prod_ready),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .acc_out(acc_out), .done(done), .busy(busy)
    );

    assign add_sum = add_a + add_b;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (rst_n) begin
            if (after_done) begin
                check("post_done_done_low", {31'b0, done}, 32'd0);
                check("post_done_busy_low", {31'b0, busy}, 32'd0);
            end
            after_done = 0;
            if (done) begin
                check("done_busy_high", {31'b0, busy}, 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got acc_out 0x%0h expected no done", acc_out);
                end else begin
                    check("acc_out", {8'b0, acc_out}, {8'b0, exp_q.pop_front()});
                end
                after_done = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 20) begin
            tick();
            k++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy 1 expected 0");
        end
        tick();
    endtask

    task automatic run_job(input int n, input word_t prods[$], input int gap,
                           input word_t expect_sum, input bit poke_start);
        exp_q.push_back(expect_sum);
        start = 1; num_terms = n[7:0];
        tick();
        start = 0; num_terms = 0;
        for (int i = 0; i < prods.size(); i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    prod_valid = 0;
                    check("stall_ready", {31'b0, prod_ready}, 32'd1);
                    tick();
                end
            end
            prod_valid = 1; prod_data = prods[i];
            if (poke_start && i == 1) begin
                start = 1; num_terms = 8'd9;
            end
            tick();
            prod_valid = 0; prod_data = 0; start = 0; num_terms = 0;
        end
        wait_idle();
    endtask

    initial begin
        rst_n = 0; start = 1; num_terms = 8'd4; prod_valid = 0; prod_data = 0;
        repeat (3) tick();
        check("rst_acc_out", {8'b0, acc_out}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_ready", {31'b0, prod_ready}, 32'd0);
        start = 0; num_terms = 0; rst_n = 1;
        tick();
        check("idle_busy", {31'b0, busy}, 32'd0);

        run_job(4, '{24'd1, 24'd2, 24'd3, 24'd4}, 0, 24'd10, 0);
        run_job(3, '{24'd100, 24'd200, 24'd300}, 2, 24'd600, 0);
        run_job(2, '{24'hFFFFFF, 24'h000002}, 0, 24'h000001, 0);

        exp_q.push_back(24'd0);
        start = 1; num_terms = 0;
        tick();
        start = 0;
        check("zero_ready", {31'b0, prod_ready}, 32'd0);
        check("zero_done", {31'b0, done}, 32'd1);
        wait_idle();

        run_job(3, '{24'd5, 24'd6, 24'd7}, 0, 24'd18, 1);

        start = 1; num_terms = 8'd5;
        tick();
        start = 0; num_terms = 0;
        prod_valid = 1; prod_data = 24'd11;
        tick();
        prod_data = 24'd22;
        tick();
        prod_valid = 0; rst_n = 0;
        tick();
        check("midrst_acc_out", {8'b0, acc_out}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        rst_n = 1;
        tick();
        run_job(1, '{24'd7}, 0, 24'd7, 0);

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
